// File: rtl/maze_pkg.sv
// Shared geometry and state encoding for the maze loader and its cell RAM.
package maze_pkg;
  localparam int DIM           = 16;
  localparam int CW            = 4;
  localparam int BYTES_PER_ROW = DIM / 8;
  localparam int TOTAL_BYTES   = DIM * DIM / 8;
  localparam int CNT_W         = $clog2(TOTAL_BYTES);
  localparam int SEG_W         = $clog2(BYTES_PER_ROW);

  typedef logic [CW-1:0] coord_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    START = 3'd3,
    SERVE = 3'd4
  } ldr_state_t;
endpackage

// File: rtl/maze_loader_mem_if.sv
// Byte-stream load channel plus the rat's cell-level read/write port.
interface maze_loader_mem_if;
  import maze_pkg::*;

  logic [7:0] InData;
  logic       InValid;
  logic       InReady;
  coord_t     RatX;
  coord_t     RatY;
  logic       RatRD;
  logic       RatWR;
  logic       RatDin;
  logic       RatDout;

  modport master (
    output InData, InValid, RatX, RatY, RatRD, RatWR, RatDin,
    input  InReady, RatDout
  );

  modport slave (
    input  InData, InValid, RatX, RatY, RatRD, RatWR, RatDin,
    output InReady, RatDout
  );
endinterface

// File: rtl/maze_ram.sv
// DIM x DIM one-bit maze store: byte-segment loader writes, single-cell rat writes,
// asynchronous cell read plus fixed taps on the entry and exit cells.
module maze_ram
  import maze_pkg::*;
(
  input  logic             clk,
  input  logic             seg_we,
  input  coord_t           seg_row,
  input  logic [SEG_W-1:0] seg_idx,
  input  logic [7:0]       seg_data,
  input  logic             cell_we,
  input  coord_t           wr_x,
  input  coord_t           wr_y,
  input  logic             cell_din,
  input  coord_t           rd_x,
  input  coord_t           rd_y,
  output logic             rd_bit,
  output logic             entry_bit,
  output logic             exit_bit
);
  logic [DIM-1:0] mem_q [DIM];

  // Loader wins; the FSM never enables both paths in the same cycle anyway.
  always_ff @(posedge clk) begin
    if (seg_we) begin
      mem_q[seg_row][{seg_idx, 3'b000} +: 8] <= seg_data;
    end else if (cell_we) begin
      mem_q[wr_y][wr_x] <= cell_din;
    end
  end

  assign rd_bit    = mem_q[rd_y][rd_x];
  assign entry_bit = mem_q[0][0];
  assign exit_bit  = mem_q[DIM-1][DIM-1];
endmodule

// File: rtl/maze_loader_mem.sv
// Loads a maze image byte by byte, validates entry/exit cells, strobes the rat,
// then serves the rat's cell read/write port.
module maze_loader_mem
  import maze_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              LoadReq,
  output logic              LoadDone,
  output logic              LoadErr,
  output logic              StartOut,
  maze_loader_mem_if.slave  bus
);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(TOTAL_BYTES - 1);

  ldr_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic xfer;
  logic serve;
  logic rd_bit, entry_bit, exit_bit;

  assign xfer  = (state_q == LOAD) && bus.InValid;
  assign serve = (state_q == SERVE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (LoadReq) begin
          state_d = LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BYTE) state_d = CHECK;
        end
      end
      CHECK: begin
        if (entry_bit || exit_bit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = START;
        end
      end
      START: state_d = SERVE;
      SERVE: begin
        if (LoadReq) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.InReady = (state_q == LOAD);
  assign LoadDone    = serve;
  assign LoadErr     = err_q;
  assign StartOut    = (state_q == START);

  // Anything other than an enabled read in SERVE looks like a wall to the rat.
  assign bus.RatDout = (serve && bus.RatRD) ? rd_bit : 1'b1;

  maze_ram u_ram (
    .clk       (CLK),
    .seg_we    (xfer),
    .seg_row   (cnt_q[CNT_W-1:SEG_W]),
    .seg_idx   (cnt_q[SEG_W-1:0]),
    .seg_data  (bus.InData),
    .cell_we   (serve && bus.RatWR),
    .wr_x      (bus.RatX),
    .wr_y      (bus.RatY),
    .cell_din  (bus.RatDin),
    .rd_x      (bus.RatX),
    .rd_y      (bus.RatY),
    .rd_bit    (rd_bit),
    .entry_bit (entry_bit),
    .exit_bit  (exit_bit)
  );
endmodule

// File: tb/tb_maze_loader_mem.sv
// Directed scenarios for the maze loader: load timing, wall mapping, entry/exit
// rejection, backpressure, rat writes and reset during a load.
module tb_maze_loader_mem;
  import maze_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  logic LoadReq;
  logic LoadDone, LoadErr, StartOut;

  maze_loader_mem_if bus();

  maze_loader_mem dut (
    .CLK      (CLK),
    .RST      (RST),
    .LoadReq  (LoadReq),
    .LoadDone (LoadDone),
    .LoadErr  (LoadErr),
    .StartOut (StartOut),
    .bus      (bus)
  );

  always #5 CLK = ~CLK;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [7:0] img [TOTAL_BYTES];

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic model_cell(input int x, input int y);
    logic [7:0] b;
    b = img[y * BYTES_PER_ROW + x / 8];
    return b[x % 8];
  endfunction

  task automatic rd_cell(input int x, input int y, output logic v);
    bus.RatX  = coord_t'(x);
    bus.RatY  = coord_t'(y);
    bus.RatRD = 1'b1;
    #1;
    v = bus.RatDout;
    bus.RatRD = 1'b0;
  endtask

  task automatic count_mismatches(output int n);
    logic v;
    n = 0;
    for (int y = 0; y < DIM; y++)
      for (int x = 0; x < DIM; x++) begin
        rd_cell(x, y, v);
        if (v !== model_cell(x, y)) n++;
      end
  endtask

  // Streams nbytes of img; 'early' counts cycles the loader was not ready mid-stream.
  task automatic do_load(input bit send_req, input bit stall, input int nbytes,
                         output int early, output bit timeout);
    int  k;
    int  cyc;
    logic rdy;
    k = 0; cyc = 0; early = 0; timeout = 1'b0;
    if (send_req) begin
      LoadReq = 1'b1;
      tick();
      LoadReq = 1'b0;
    end
    while (k < nbytes && !timeout) begin
      bus.InValid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.InData  = img[k];
      rdy = bus.InReady;
      if (rdy !== 1'b1) early++;
      @(posedge CLK);
      if (bus.InValid && rdy === 1'b1) k++;
      #1;
      cyc++;
      if (cyc > 400) timeout = 1'b1;
    end
    bus.InValid = 1'b0;
  endtask

  task automatic post_load(output logic s0, output logic s1, output logic s2, output logic d2);
    s0 = StartOut;
    tick();
    s1 = StartOut;
    tick();
    s2 = StartOut;
    d2 = LoadDone;
  endtask

  task automatic test_reset;
    logic v;
    RST = 1'b0;
    tick();
    tick();
    total_cnt++; if (bus.InReady !== 1'b0) $display("FAIL reset_inready: got %b expected 0", bus.InReady); else pass_cnt++;
    total_cnt++; if (LoadDone !== 1'b0) $display("FAIL reset_loaddone: got %b expected 0", LoadDone); else pass_cnt++;
    total_cnt++; if (LoadErr !== 1'b0) $display("FAIL reset_loaderr: got %b expected 0", LoadErr); else pass_cnt++;
    total_cnt++; if (StartOut !== 1'b0) $display("FAIL reset_startout: got %b expected 0", StartOut); else pass_cnt++;
    rd_cell(0, 0, v);
    total_cnt++; if (v !== 1'b1) $display("FAIL reset_ratdout: got %b expected 1", v); else pass_cnt++;
    RST = 1'b1;
    tick();
  endtask

  task automatic test_all_zero;
    int early; bit to; logic s0, s1, s2, d2, v;
    foreach (img[k]) img[k] = 8'h00;
    do_load(1'b1, 1'b0, TOTAL_BYTES, early, to);
    total_cnt++; if (early != 0 || to) $display("FAIL zero_inready: not_ready=%0d timeout=%0d expected 0/0", early, to); else pass_cnt++;
    post_load(s0, s1, s2, d2);
    total_cnt++; if ({s0, s1, s2} !== 3'b010) $display("FAIL zero_start_timing: got %b expected 010", {s0, s1, s2}); else pass_cnt++;
    total_cnt++; if (d2 !== 1'b1 || LoadErr !== 1'b0) $display("FAIL zero_done: done=%b err=%b expected 1/0", d2, LoadErr); else pass_cnt++;
    rd_cell(5, 9, v);
    total_cnt++; if (v !== 1'b0) $display("FAIL zero_read_5_9: got %b expected 0", v); else pass_cnt++;
  endtask

  task automatic test_wall;
    int early; bit to; logic s0, s1, s2, d2, v;
    foreach (img[k]) img[k] = 8'h00;
    img[19] = 8'h04;
    do_load(1'b1, 1'b0, TOTAL_BYTES, early, to);
    post_load(s0, s1, s2, d2);
    total_cnt++; if (s1 !== 1'b1 || d2 !== 1'b1) $display("FAIL wall_start: start=%b done=%b expected 1/1", s1, d2); else pass_cnt++;
    rd_cell(10, 9, v);
    total_cnt++; if (v !== 1'b1) $display("FAIL wall_read_10_9: got %b expected 1", v); else pass_cnt++;
    rd_cell(9, 9, v);
    total_cnt++; if (v !== 1'b0) $display("FAIL wall_read_9_9: got %b expected 0", v); else pass_cnt++;
    rd_cell(10, 8, v);
    total_cnt++; if (v !== 1'b0) $display("FAIL wall_read_10_8: got %b expected 0", v); else pass_cnt++;
  endtask

  task automatic test_bad_corner;
    int early; bit to; logic s0, s1, s2, d2, v;
    for (int c = 0; c < 2; c++) begin
      foreach (img[k]) img[k] = 8'h00;
      if (c == 0) img[0] = 8'h01;
      else        img[TOTAL_BYTES-1] = 8'h80;
      do_load(1'b1, 1'b0, TOTAL_BYTES, early, to);
      post_load(s0, s1, s2, d2);
      total_cnt++; if ({s0, s1, s2} !== 3'b000) $display("FAIL bad%0d_no_start: got %b expected 000", c, {s0, s1, s2}); else pass_cnt++;
      total_cnt++; if (LoadErr !== 1'b1 || d2 !== 1'b0 || bus.InReady !== 1'b0) $display("FAIL bad%0d_err_idle: err=%b done=%b rdy=%b expected 1/0/0", c, LoadErr, d2, bus.InReady); else pass_cnt++;
      rd_cell(5, 5, v);
      total_cnt++; if (v !== 1'b1) $display("FAIL bad%0d_read_wall: got %b expected 1", c, v); else pass_cnt++;
    end
    LoadReq = 1'b1;
    tick();
    LoadReq = 1'b0;
    total_cnt++; if (LoadErr !== 1'b0 || bus.InReady !== 1'b1) $display("FAIL bad_err_clear: err=%b rdy=%b expected 0/1", LoadErr, bus.InReady); else pass_cnt++;
    foreach (img[k]) img[k] = 8'h00;
    do_load(1'b0, 1'b0, TOTAL_BYTES, early, to);
    post_load(s0, s1, s2, d2);
    total_cnt++; if (s1 !== 1'b1 || d2 !== 1'b1) $display("FAIL bad_recover: start=%b done=%b expected 1/1", s1, d2); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    int early; bit to; int n; logic s0, s1, s2, d2;
    foreach (img[k]) img[k] = 8'((k * 37 + 5) & 8'h7E);
    do_load(1'b1, 1'b1, TOTAL_BYTES, early, to);
    total_cnt++; if (early != 0 || to) $display("FAIL bp_count: not_ready=%0d timeout=%0d expected 0/0", early, to); else pass_cnt++;
    post_load(s0, s1, s2, d2);
    total_cnt++; if ({s0, s1, s2} !== 3'b010) $display("FAIL bp_start: got %b expected 010", {s0, s1, s2}); else pass_cnt++;
    count_mismatches(n);
    total_cnt++; if (n != 0) $display("FAIL bp_image: got %0d bad cells expected 0", n); else pass_cnt++;
  endtask

  task automatic test_rat_write;
    int early; bit to; logic s0, s1, s2, d2, v;
    foreach (img[k]) img[k] = 8'h00;
    bus.RatX = coord_t'(4); bus.RatY = coord_t'(4); bus.RatDin = 1'b1; bus.RatWR = 1'b1;
    do_load(1'b1, 1'b0, TOTAL_BYTES, early, to);
    bus.RatWR = 1'b0;
    post_load(s0, s1, s2, d2);
    rd_cell(4, 4, v);
    total_cnt++; if (v !== 1'b0) $display("FAIL rw_load_drop: got %b expected 0", v); else pass_cnt++;
    bus.RatX = coord_t'(3); bus.RatY = coord_t'(3); bus.RatDin = 1'b1;
    bus.RatRD = 1'b1; bus.RatWR = 1'b1;
    #1;
    total_cnt++; if (bus.RatDout !== 1'b0) $display("FAIL rw_same_cycle: got %b expected 0", bus.RatDout); else pass_cnt++;
    tick();
    bus.RatWR = 1'b0;
    #1;
    total_cnt++; if (bus.RatDout !== 1'b1) $display("FAIL rw_next_cycle: got %b expected 1", bus.RatDout); else pass_cnt++;
    bus.RatX = coord_t'(2);
    #1;
    total_cnt++; if (bus.RatDout !== 1'b0) $display("FAIL rw_neighbour: got %b expected 0", bus.RatDout); else pass_cnt++;
    bus.RatRD = 1'b0;
    #1;
    total_cnt++; if (bus.RatDout !== 1'b1) $display("FAIL rw_rd_low: got %b expected 1", bus.RatDout); else pass_cnt++;
  endtask

  task automatic test_reset_mid_load;
    int early; bit to; int n; logic s0, s1, s2, d2;
    foreach (img[k]) img[k] = 8'hAA;
    do_load(1'b1, 1'b0, 10, early, to);
    RST = 1'b0;
    tick();
    RST = 1'b1;
    total_cnt++; if (bus.InReady !== 1'b0 || LoadDone !== 1'b0 || StartOut !== 1'b0) $display("FAIL mid_reset: rdy=%b done=%b start=%b expected 0/0/0", bus.InReady, LoadDone, StartOut); else pass_cnt++;
    tick();
    total_cnt++; if (bus.InReady !== 1'b0) $display("FAIL mid_idle_hold: got %b expected 0", bus.InReady); else pass_cnt++;
    foreach (img[k]) img[k] = 8'((k * 11) & 8'h7E);
    do_load(1'b1, 1'b0, TOTAL_BYTES, early, to);
    total_cnt++; if (early != 0 || to) $display("FAIL mid_reload: not_ready=%0d timeout=%0d expected 0/0", early, to); else pass_cnt++;
    post_load(s0, s1, s2, d2);
    total_cnt++; if ({s0, s1, s2} !== 3'b010 || d2 !== 1'b1) $display("FAIL mid_start: got %b done=%b expected 010/1", {s0, s1, s2}, d2); else pass_cnt++;
    count_mismatches(n);
    total_cnt++; if (n != 0) $display("FAIL mid_image: got %0d bad cells expected 0", n); else pass_cnt++;
  endtask

  initial begin
    RST = 1'b1; LoadReq = 1'b0;
    bus.InData = 8'h00; bus.InValid = 1'b0;
    bus.RatX = '0; bus.RatY = '0; bus.RatRD = 1'b0; bus.RatWR = 1'b0; bus.RatDin = 1'b0;
    test_reset();
    test_all_zero();
    test_wall();
    test_bad_corner();
    test_backpressure();
    test_rat_write();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
